// File: rtl/param_scan_decoder.sv
// rtl/param_scan_decoder.sv - registered N-to-2^N one-hot decoder with a dwell-timed scan mode
module param_scan_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DWELL      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         start,
  output logic [(1<<ADDR_WIDTH)-1:0]   out,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        cur_addr
);

  localparam int LINES = 1 << ADDR_WIDTH;
  localparam int DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0]        DWELL_LOAD = DCW'(DWELL - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_LOAD  = ADDR_WIDTH'(LINES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state;
  logic [DCW-1:0]          dwell_cnt;
  logic [ADDR_WIDTH-1:0]   line_cnt;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign next_addr = cur_addr + ADDR_WIDTH'(1);

  function automatic logic [LINES-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [LINES-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  // DONE evaluates the IDLE rules on its own edge so back-to-back scans see a single zero cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_addr  <= '0;
      dwell_cnt <= '0;
      line_cnt  <= '0;
    end else if (state == SCAN) begin
      if (!enable) begin
        state <= IDLE;
        out   <= '0;
        busy  <= 1'b0;
      end else if (dwell_cnt != '0) begin
        dwell_cnt <= dwell_cnt - DCW'(1);
      end else if (line_cnt != '0) begin
        cur_addr  <= next_addr;
        out       <= decode(next_addr);
        dwell_cnt <= DWELL_LOAD;
        line_cnt  <= line_cnt - ADDR_WIDTH'(1);
      end else begin
        state <= DONE;
        out   <= '0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      done  <= 1'b0;
      busy  <= 1'b0;
      state <= IDLE;
      if (!enable) begin
        out <= '0;
      end else if (!mode) begin
        out      <= decode(address);
        cur_addr <= address;
      end else if (start) begin
        state     <= SCAN;
        out       <= decode(address);
        cur_addr  <= address;
        dwell_cnt <= DWELL_LOAD;
        line_cnt  <= LINE_LOAD;
        busy      <= 1'b1;
      end else begin
        out <= '0;
      end
    end
  end

endmodule

// File: doc/param_scan_decoder.md
Name: param_scan_decoder

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It is the successor to the team's combinational 2-to-4 enable decoder. Two modes:
- Direct mode: registered decode of the input address.
- Scan mode: an internal FSM sweeps the one-hot output across all 2^N lines, holding each line for a programmable dwell time, then signals completion.

It drives chip-select, row-select and mux-select lines in the team's register-file and memory designs.

Parameters:
ADDR_WIDTH, 2, address width N; the output width is 2**ADDR_WIDTH (min 1, max 6).
DWELL, 1, cycles each output line stays asserted during a scan (min 1, max 255).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  global enable; when low, all outputs go to 0 and any scan is aborted.
mode  input  1  0 = direct decode, 1 = scan; sampled only in IDLE.
address  input  ADDR_WIDTH  decode address (direct) or scan start index (scan, captured on start).
start  input  1  scan request; acted on only in IDLE with mode=1 and enable=1.
out  output  2**ADDR_WIDTH  registered one-hot (or all-zero) select lines.
busy  output  1  high while in SCAN.
done  output  1  one-cycle pulse when a scan completes normally.
cur_addr  output  ADDR_WIDTH  index currently driven on out (registered).

Behaviour:
Reset (asynchronous, active-high):
- out=0, busy=0, done=0, cur_addr=0, dwell counter=0, line counter=0, state=IDLE.
- Release takes effect on the next clk edge.

States are IDLE, SCAN and DONE.

IDLE:
- mode=0, enable=1: next out = 1<<address and cur_addr=address. Latency is exactly 1 cycle, and out tracks address every cycle.
- mode=0, enable=0: next out=0; cur_addr holds its value.
- mode=1 with no start: next out=0.
- mode=1, enable=1, start=1:
  - capture address into cur_addr;
  - next out = 1<<address;
  - load dwell counter with DWELL-1 and line counter with 2**ADDR_WIDTH-1;
  - go to SCAN with busy=1.
- start with enable=0 is ignored.

SCAN:
- If dwell counter != 0: decrement it; out and cur_addr hold.
- Else if line counter != 0:
  - cur_addr = cur_addr+1, wrapping modulo 2**ADDR_WIDTH;
  - out = 1<<(new cur_addr);
  - reload dwell counter with DWELL-1;
  - decrement line counter.
- Else (final line has finished its dwell): go to DONE; next out=0, busy=0, done=1.
- Every line is asserted exactly DWELL cycles. A full scan occupies 2**ADDR_WIDTH*DWELL cycles of busy.
- enable=0 in any SCAN cycle aborts the scan: next out=0, busy=0, done stays 0, state=IDLE, cur_addr holds.
- start, mode and address are ignored during SCAN.

DONE:
- Lasts one cycle; done returns to 0 and state returns to IDLE.
- The IDLE rules then apply, so a start present on that IDLE cycle begins a new scan.
- Back-to-back scans therefore have out=0 for exactly one cycle (the DONE cycle).

Invariants:
- out is always one-hot or zero; never more than one bit set.
- busy and done are never high together.
- The counter widths must hold DWELL-1 and 2**ADDR_WIDTH-1 without overflow.

Reset mid-scan forces the reset values immediately, without waiting for clk.

Test Plan:
1. Direct, ADDR_WIDTH=2, enable=1, mode=0: address 0,1,2,3 on successive cycles -> out = 0001, 0010, 0100, 1000, each one cycle later; busy=0 and done=0 throughout.
2. Direct enable gating: address=2 with enable toggled 1,0,1 -> out = 0100, 0000, 0100 with 1-cycle latency. Also confirm ADDR_WIDTH=3, address=5 gives out=00100000.
3. Scan with wrap, ADDR_WIDTH=2, DWELL=2: start pulse with address=2 ->
   - out = 0100 for 2 cycles, then 1000, 0001, 0010 for 2 cycles each;
   - cur_addr sequence 2,3,0,1; busy high for 8 cycles;
   - then done=1 for 1 cycle with out=0.
4. Scan abort, DWELL=1: start with address=0, then drop enable in the third SCAN cycle -> the next edge gives out=0, busy=0, done never asserts, state IDLE; the next start restarts cleanly.
5. Ignored inputs: assert start again, toggle mode and change address during SCAN -> the scan sequence is unchanged. Hold start and mode=1 through DONE -> a new scan begins after exactly one out=0 cycle.
6. Asynchronous reset: assert reset mid-scan between clock edges -> out=0, busy=0, done=0, cur_addr=0 immediately. After release, direct decode of address=3 gives out=1000 on the next edge.
